// File: rtl/branch_predictor_btb_if.sv
// rtl/branch_predictor_btb_if.sv - Execute-stage training and redirect bus of the BTB predictor
interface branch_predictor_btb_if;
  logic        i_upd_vld;
  logic [31:0] i_upd_pc;
  logic        i_upd_is_jump;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        o_mispred;
  logic [31:0] o_redirect_pc;

  modport master (
    output i_upd_vld, i_upd_pc, i_upd_is_jump, i_upd_taken, i_upd_target,
           i_upd_pred_taken, i_upd_pred_target,
    input  o_mispred, o_redirect_pc
  );

  modport slave (
    input  i_upd_vld, i_upd_pc, i_upd_is_jump, i_upd_taken, i_upd_target,
           i_upd_pred_taken, i_upd_pred_target,
    output o_mispred, o_redirect_pc
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - Direct-mapped BTB with saturating direction counters
module branch_predictor_btb #(
  parameter int ENTRIES   = 64,
  parameter int CNT_W     = 2,
  parameter int PRED_MODE = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_f,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_clear,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count,
  branch_predictor_btb_if.slave upd
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_ONE << (CNT_W - 1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [31:0]      r_br_count;
  logic [31:0]      r_mispred_count;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic             w_pred_taken;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_mispred;
  logic             w_unused;

  // Fetch lookup; pc[1:0] never selects an entry.
  assign w_f_idx       = i_pc_f[IDX_W+1:2];
  assign w_f_tag       = i_pc_f[31:IDX_W+2];
  assign w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_pred_taken  = (PRED_MODE != 0) && w_f_hit &&
                         (r_jump[w_f_idx] || r_cnt[w_f_idx][CNT_W-1]);
  assign o_pred_taken  = w_pred_taken;
  assign o_pred_target = w_pred_taken ? r_target[w_f_idx] : 32'd0;

  assign w_u_idx = upd.i_upd_pc[IDX_W+1:2];
  assign w_u_tag = upd.i_upd_pc[31:IDX_W+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // A correct direction with a wrong target still needs a redirect.
  assign w_mispred = upd.i_upd_vld &&
                     ((upd.i_upd_pred_taken != upd.i_upd_taken) ||
                      (upd.i_upd_taken && (upd.i_upd_pred_target != upd.i_upd_target)));
  assign upd.o_mispred     = w_mispred;
  assign upd.o_redirect_pc = !upd.i_upd_vld ? 32'd0 :
                             upd.i_upd_taken ? upd.i_upd_target : upd.i_upd_pc + 32'd4;

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;
  assign w_unused        = ^{i_pc_f[1:0], upd.i_upd_pc[1:0]};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
        r_jump[i]   <= 1'b0;
      end
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (upd.i_upd_vld) begin
        r_br_count <= r_br_count + 32'd1;
        if (w_mispred) begin
          r_mispred_count <= r_mispred_count + 32'd1;
        end
        if (w_u_hit) begin
          if (upd.i_upd_taken) begin
            if (r_cnt[w_u_idx] != CNT_MAX) begin
              r_cnt[w_u_idx] <= r_cnt[w_u_idx] + CNT_ONE;
            end
            r_target[w_u_idx] <= upd.i_upd_target;
            r_jump[w_u_idx]   <= upd.i_upd_is_jump;
          end else if (r_cnt[w_u_idx] != '0) begin
            r_cnt[w_u_idx] <= r_cnt[w_u_idx] - CNT_ONE;
          end
        end else if (upd.i_upd_taken) begin
          r_valid[w_u_idx]  <= 1'b1;
          r_tag[w_u_idx]    <= w_u_tag;
          r_target[w_u_idx] <= upd.i_upd_target;
          r_jump[w_u_idx]   <= upd.i_upd_is_jump;
          r_cnt[w_u_idx]    <= CNT_WEAK;
        end
      end
      // Placed last so a same-cycle allocation loses its valid bit.
      if (i_clear) begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - Directed self-checking bench for branch_predictor_btb
module tb_branch_predictor_btb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        clear;
  logic        pred_taken1, pred_taken0;
  logic [31:0] pred_target1, pred_target0;
  logic [31:0] br_count1, br_count0, mis_count1, mis_count0;
  int          checks = 0;
  int          failures = 0;

  branch_predictor_btb_if u_if1 ();
  branch_predictor_btb_if u_if0 ();

  assign u_if0.i_upd_vld         = u_if1.i_upd_vld;
  assign u_if0.i_upd_pc          = u_if1.i_upd_pc;
  assign u_if0.i_upd_is_jump     = u_if1.i_upd_is_jump;
  assign u_if0.i_upd_taken       = u_if1.i_upd_taken;
  assign u_if0.i_upd_target      = u_if1.i_upd_target;
  assign u_if0.i_upd_pred_taken  = u_if1.i_upd_pred_taken;
  assign u_if0.i_upd_pred_target = u_if1.i_upd_pred_target;

  branch_predictor_btb #(.ENTRIES(64), .CNT_W(2), .PRED_MODE(1)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_pc_f(pc_f),
    .o_pred_taken(pred_taken1), .o_pred_target(pred_target1),
    .i_clear(clear), .o_br_count(br_count1), .o_mispred_count(mis_count1),
    .upd(u_if1.slave)
  );

  branch_predictor_btb #(.ENTRIES(64), .CNT_W(2), .PRED_MODE(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_pc_f(pc_f),
    .o_pred_taken(pred_taken0), .o_pred_target(pred_target0),
    .i_clear(clear), .o_br_count(br_count0), .o_mispred_count(mis_count0),
    .upd(u_if0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic is_jump, input logic taken,
                     input logic [31:0] target, input logic pt, input logic [31:0] ptgt);
    u_if1.i_upd_vld         = 1'b1;
    u_if1.i_upd_pc          = pc;
    u_if1.i_upd_is_jump     = is_jump;
    u_if1.i_upd_taken       = taken;
    u_if1.i_upd_target      = target;
    u_if1.i_upd_pred_taken  = pt;
    u_if1.i_upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    u_if1.i_upd_vld = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    pc_f  = 32'h100;
    idle();
    #7;
    chk("in_reset_pred_taken", {31'd0, pred_taken1}, 32'd0);
    chk("in_reset_pred_target", pred_target1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cold_pred_taken", {31'd0, pred_taken1}, 32'd0);
    chk("cold_pred_target", pred_target1, 32'd0);
    chk("cold_br_count", br_count1, 32'd0);
    chk("cold_mis_count", mis_count1, 32'd0);
    chk("idle_mispred", {31'd0, u_if1.o_mispred}, 32'd0);
    chk("idle_redirect", u_if1.o_redirect_pc, 32'd0);

    // Allocate 0x100 -> 0x80
    upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("alloc_mispred", {31'd0, u_if1.o_mispred}, 32'd1);
    chk("alloc_redirect", u_if1.o_redirect_pc, 32'h80);
    chk("alloc_same_cycle_lookup", {31'd0, pred_taken1}, 32'd0);
    step(); idle(); #1;
    chk("alloc_pred_taken", {31'd0, pred_taken1}, 32'd1);
    chk("alloc_pred_target", pred_target1, 32'h80);
    chk("alloc_mis_count", mis_count1, 32'd1);
    chk("alloc_br_count", br_count1, 32'd1);
    chk("static_pred_taken", {31'd0, pred_taken0}, 32'd0);
    chk("static_pred_target", pred_target0, 32'd0);
    chk("static_mis_count", mis_count0, 32'd1);

    // Hysteresis: cnt 2 -> 1 -> 0, then saturate at 3
    upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("nt_mispred", {31'd0, u_if1.o_mispred}, 32'd1);
    chk("nt_redirect", u_if1.o_redirect_pc, 32'h104);
    step(); idle(); #1;
    chk("cnt1_pred_taken", {31'd0, pred_taken1}, 32'd0);
    upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    #1;
    chk("nt_correct_mispred", {31'd0, u_if1.o_mispred}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
      step();
    end
    idle(); #1;
    chk("sat_pred_taken", {31'd0, pred_taken1}, 32'd1);
    upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    step(); idle(); #1;
    chk("sat_minus1_pred_taken", {31'd0, pred_taken1}, 32'd1);
    upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    step(); idle(); #1;
    chk("sat_minus2_pred_taken", {31'd0, pred_taken1}, 32'd0);
    chk("hyst_br_count", br_count1, 32'd9);
    chk("hyst_mis_count", mis_count1, 32'd8);

    // Alias eviction at index 0
    upd(32'h200, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    step(); idle();
    pc_f = 32'h100; #1;
    chk("alias_old_miss", {31'd0, pred_taken1}, 32'd0);
    pc_f = 32'h200; #1;
    chk("alias_new_taken", {31'd0, pred_taken1}, 32'd1);
    chk("alias_new_target", pred_target1, 32'h40);

    // Jump with wrong target, then counter driven low
    upd(32'h10, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    step(); idle();
    pc_f = 32'h10; #1;
    chk("jump_alloc_target", pred_target1, 32'h20);
    upd(32'h10, 1'b1, 1'b1, 32'h24, 1'b1, 32'h20);
    #1;
    chk("jump_wrong_tgt_mispred", {31'd0, u_if1.o_mispred}, 32'd1);
    chk("jump_wrong_tgt_redirect", u_if1.o_redirect_pc, 32'h24);
    step(); idle(); #1;
    chk("jump_retarget", pred_target1, 32'h24);
    for (int i = 0; i < 3; i++) begin
      upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
    end
    idle(); #1;
    chk("jump_low_cnt_taken", {31'd0, pred_taken1}, 32'd1);
    chk("jump_low_cnt_target", pred_target1, 32'h24);
    upd(32'h10, 1'b1, 1'b1, 32'h24, 1'b1, 32'h24);
    #1;
    chk("right_tgt_mispred", {31'd0, u_if1.o_mispred}, 32'd0);
    chk("right_tgt_redirect", u_if1.o_redirect_pc, 32'h24);
    step(); idle(); #1;
    chk("jump_br_count", br_count1, 32'd16);
    chk("jump_mis_count", mis_count1, 32'd11);

    // Clear with same-cycle allocate
    upd(32'h300, 1'b0, 1'b1, 32'h60, 1'b0, 32'h0);
    clear = 1'b1;
    step(); idle();
    clear = 1'b0;
    pc_f = 32'h300; #1;
    chk("clear_alloc_discarded", {31'd0, pred_taken1}, 32'd0);
    pc_f = 32'h200; #1;
    chk("clear_idx0_invalid", {31'd0, pred_taken1}, 32'd0);
    pc_f = 32'h10; #1;
    chk("clear_jump_invalid", {31'd0, pred_taken1}, 32'd0);
    chk("clear_br_count", br_count1, 32'd17);
    chk("clear_mis_count", mis_count1, 32'd12);

    // Asynchronous reset mid-cycle
    upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    step(); idle();
    pc_f = 32'h100; #1;
    chk("prereset_pred_taken", {31'd0, pred_taken1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pred_taken", {31'd0, pred_taken1}, 32'd0);
    chk("async_reset_pred_target", pred_target1, 32'd0);
    chk("async_reset_br_count", br_count1, 32'd0);
    chk("async_reset_mis_count", mis_count1, 32'd0);
    chk("async_reset_static_br", br_count0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
